pc_sequencer: RTL and testbench

Fetch/commit controller for the program counter of the RISC-V core. It owns the PC register and sequences each instruction through an instruction-memory request/acknowledge handshake. It presents the fetched word to the datapath and, when the datapath commits, selects the next PC: sequential, branch/jump redirect, trap, or return. It also detects halt and fetch-fault conditions.

---
 rtl/pc_sequencer_if.sv | 34 +++
 rtl/pc_sequencer.sv | 99 +++++++++
 tb/tb_pc_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-memory handshake and datapath commit bundle.
// Trap/mret/mepc signals exist only when PC_SEQ_TRAP_EN is defined.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        commit;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        halt;
`ifdef PC_SEQ_TRAP_EN
  logic        trap;
  logic        mret;
  logic [31:0] mepc;
`endif
  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_ack, imem_rdata, commit, stall, redirect, redirect_target, halt
`ifdef PC_SEQ_TRAP_EN
    , input trap, mret, output mepc
`endif
  );
  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_ack, imem_rdata, commit, stall, redirect, redirect_target, halt
`ifdef PC_SEQ_TRAP_EN
    , output trap, mret, input mepc
`endif
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC owner that fetches over a req/ack handshake and picks the next PC on commit.
// Define PC_SEQ_TRAP_EN to add trap/mret handling with the mepc register.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
`ifdef PC_SEQ_TRAP_EN
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
`endif
  parameter int          MAX_WAIT     = 8
) (
  input  logic               clk,
  input  logic               reset,
  pc_sequencer_if.master     bus,
  output logic [31:0]        pc,
  output logic               halted,
  output logic               fetch_fault
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, HALT, FAULT} state_t;
  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [31:0] pc_n, instr, instr_n, sel;
  logic        valid, valid_n, halted_n, fault_n, go;
`ifdef PC_SEQ_TRAP_EN
  logic [31:0] mepc, mepc_n;
  assign sel = bus.trap ? TRAP_VECTOR : bus.mret ? mepc : bus.redirect ? bus.redirect_target : pc + 32'd4;
  assign bus.mepc = mepc;
`else
  assign sel = bus.redirect ? bus.redirect_target : pc + 32'd4;
`endif
  assign go              = state == EXEC && bus.commit && !bus.stall;
  assign bus.imem_req    = state == FETCH;
  assign bus.imem_addr   = pc;
  assign bus.instr       = instr;
  assign bus.instr_valid = valid;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      pc          <= RESET_VECTOR;
      instr       <= '0;
      valid       <= 1'b0;
      halted      <= 1'b0;
      fetch_fault <= 1'b0;
`ifdef PC_SEQ_TRAP_EN
      mepc        <= '0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pc          <= pc_n;
      instr       <= instr_n;
      valid       <= valid_n;
      halted      <= halted_n;
      fetch_fault <= fault_n;
`ifdef PC_SEQ_TRAP_EN
      mepc        <= mepc_n;
`endif
    end
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pc_n     = pc;
    instr_n  = instr;
    valid_n  = valid;
    halted_n = halted;
    fault_n  = fetch_fault;
`ifdef PC_SEQ_TRAP_EN
    mepc_n   = mepc;
`endif
    case (state)
      IDLE: state_n = FETCH;
      FETCH:
        if (bus.imem_ack) begin
          instr_n = bus.imem_rdata;
          valid_n = 1'b1;
          cnt_n   = '0;
          state_n = EXEC;
        end else begin
          cnt_n   = cnt + 8'd1;
          state_n = cnt_n == 8'(MAX_WAIT) ? FAULT : FETCH;
          fault_n = fetch_fault | (cnt_n == 8'(MAX_WAIT));
        end
      EXEC:
        if (go && bus.halt) begin
          state_n  = HALT;
          halted_n = 1'b1;
        end else if (go) begin
          pc_n    = sel;
          valid_n = 1'b0;
          // a misaligned target still loads pc so the faulting address is visible
          state_n = sel[1:0] != 2'b00 ? FAULT : FETCH;
          fault_n = fetch_fault | (sel[1:0] != 2'b00);
`ifdef PC_SEQ_TRAP_EN
          mepc_n  = bus.trap ? pc : mepc;
`endif
        end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test-plan scenarios plus randomized episodes checked every cycle
// against a transaction-level model of the sequencer.
module tb_pc_sequencer;
  localparam int MAX_WAIT = 8;
  localparam logic [31:0] RV = 32'h0000_0000;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] pc;
  logic halted, fetch_fault;
  int checks = 0;
  int errors = 0;
  bit started = 0;
  pc_sequencer_if bus();
  pc_sequencer #(.RESET_VECTOR(RV), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .bus(bus.master), .pc(pc), .halted(halted), .fetch_fault(fetch_fault)
  );
  always #5 clk = ~clk;
  // model: phase 0 = just out of reset, 1 = waiting for fetch, 2 = holding an instruction, 3 = stopped
  int          m_phase, m_wait;
  logic [31:0] m_pc, m_instr, m_mepc, nxt;
  logic        m_valid, m_halted, m_fault;
  always @(posedge clk or negedge reset)
    if (!reset) begin
      m_phase = 0; m_wait = 0; m_pc = RV; m_instr = 0; m_mepc = 0;
      m_valid = 0; m_halted = 0; m_fault = 0;
    end else if (m_phase == 0) m_phase = 1;
    else if (m_phase == 1) begin
      if (bus.imem_ack) begin
        m_instr = bus.imem_rdata; m_valid = 1; m_phase = 2; m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait >= MAX_WAIT) begin m_phase = 3; m_fault = 1; end
      end
    end else if (m_phase == 2 && bus.commit && !bus.stall) begin
      if (bus.halt) begin m_phase = 3; m_halted = 1; end
      else begin
        nxt = m_pc + 4;
        if (bus.redirect) nxt = bus.redirect_target;
`ifdef PC_SEQ_TRAP_EN
        if (bus.mret) nxt = m_mepc;
        if (bus.trap) begin nxt = 32'h100; m_mepc = m_pc; end
`endif
        m_pc = nxt; m_valid = 0;
        if (nxt % 4 != 0) begin m_phase = 3; m_fault = 1; end
        else m_phase = 1;
      end
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) if (started) begin
    chk("imem_req", 32'(bus.imem_req), 32'(m_phase == 1));
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("instr", bus.instr, m_instr);
    chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
`ifdef PC_SEQ_TRAP_EN
    chk("mepc", bus.mepc, m_mepc);
`endif
  end
  task automatic clear_in();
    bus.imem_ack = 0; bus.imem_rdata = 0; bus.commit = 0; bus.stall = 0;
    bus.redirect = 0; bus.redirect_target = 0; bus.halt = 0;
`ifdef PC_SEQ_TRAP_EN
    bus.trap = 0; bus.mret = 0;
`endif
  endtask
  task automatic step(); @(negedge clk); endtask
  // reset edges land mid-phase so they never race the negedge compare
  task automatic do_reset();
    clear_in();
    @(negedge clk); #2 reset = 0;
    @(negedge clk); @(negedge clk); #2 reset = 1;
  endtask
  task automatic fetch_ok(input logic [31:0] w);
    bus.imem_ack = 1; bus.imem_rdata = w; step(); bus.imem_ack = 0;
  endtask
  int ack_pct, com_pct, mis_pct;
  initial begin
    clear_in();
    #1 chk("reset pc", pc, RV);
    chk("reset req", 32'(bus.imem_req), 0);
    started = 1;
    do_reset();
    step();
    fetch_ok(32'h0050_0093);
    chk("tp1 instr", bus.instr, 32'h0050_0093);
    chk("tp1 valid", 32'(bus.instr_valid), 1);
    bus.commit = 1; step(); bus.commit = 0;
    chk("tp1 pc", pc, 32'h4);
    chk("tp1 req", 32'(bus.imem_req), 1);
    do_reset();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("tp2 addr", bus.imem_addr, 32'h0);
      chk("tp2 req", 32'(bus.imem_req), 1);
      bus.imem_ack = (i == 3); bus.imem_rdata = 32'h1234_5678; step();
    end
    bus.imem_ack = 0;
    chk("tp2 valid", 32'(bus.instr_valid), 1);
    chk("tp2 fault", 32'(fetch_fault), 0);
    bus.commit = 1; bus.stall = 1; step();
    chk("tp3 pc stall1", pc, 32'h0);
    step();
    chk("tp3 pc stall2", pc, 32'h0);
    bus.stall = 0; step(); bus.commit = 0;
    chk("tp3 pc go", pc, 32'h4);
    fetch_ok(32'h0000_0013);
    bus.commit = 1; bus.redirect = 1; bus.redirect_target = 32'h40; step();
    bus.commit = 0; bus.redirect = 0;
    chk("tp4 addr", bus.imem_addr, 32'h40);
    fetch_ok(32'h0000_0013);
    bus.commit = 1; bus.redirect = 1; bus.redirect_target = 32'h42; step();
    bus.commit = 0; bus.redirect = 0;
    chk("tp4 misalign fault", 32'(fetch_fault), 1);
    chk("tp4 misalign pc", pc, 32'h42);
    do_reset();
    step();
    for (int i = 0; i < MAX_WAIT; i++) begin
      chk("tp5 pre fault", 32'(fetch_fault), 0);
      step();
    end
    chk("tp5 fault", 32'(fetch_fault), 1);
    chk("tp5 req", 32'(bus.imem_req), 0);
    bus.imem_ack = 1; step(); step();
    chk("tp5 sticky", 32'(fetch_fault), 1);
    #2 reset = 0;
    #1 chk("tp5 async pc", pc, RV);
    chk("tp5 async fault", 32'(fetch_fault), 0);
    do_reset();
    step();
    fetch_ok(32'h0000_0013);
    bus.commit = 1; bus.redirect = 1; bus.redirect_target = 32'h20; step();
    bus.commit = 0; bus.redirect = 0;
    fetch_ok(32'h0000_0073);
`ifdef PC_SEQ_TRAP_EN
    bus.commit = 1; bus.trap = 1; step(); bus.commit = 0; bus.trap = 0;
    chk("tp6 mepc", bus.mepc, 32'h20);
    chk("tp6 trap pc", pc, 32'h100);
    fetch_ok(32'h3020_0073);
    bus.commit = 1; bus.mret = 1; step(); bus.commit = 0; bus.mret = 0;
    chk("tp6 mret pc", pc, 32'h20);
    fetch_ok(32'h0010_0073);
`endif
    bus.commit = 1; bus.halt = 1; bus.redirect = 1; bus.redirect_target = 32'h80; step();
    clear_in();
    chk("tp6 halted", 32'(halted), 1);
    chk("tp6 halt pc", pc, 32'h20);
    for (int i = 0; i < 3; i++) begin
      bus.imem_ack = 1; bus.commit = 1; step();
      chk("tp6 no req", 32'(bus.imem_req), 0);
    end
    for (int e = 0; e < 30; e++) begin
      do_reset();
      ack_pct = (e % 7 == 3) ? 0 : $urandom_range(20, 100);
      com_pct = $urandom_range(30, 100);
      mis_pct = (e % 3 == 0) ? 10 : 0;
      for (int c = 0; c < 80; c++) begin
        step();
        bus.imem_ack = $urandom_range(0, 99) < ack_pct;
        bus.imem_rdata = $urandom;
        bus.commit = $urandom_range(0, 99) < com_pct;
        bus.stall = $urandom_range(0, 99) < 30;
        bus.redirect = $urandom_range(0, 99) < 30;
        bus.redirect_target = {$urandom_range(0, 32'h3FFF_FFFF) << 2} |
                              (($urandom_range(0, 99) < mis_pct) ? 32'($urandom_range(1, 3)) : 32'h0);
        bus.halt = $urandom_range(0, 99) < 3;
`ifdef PC_SEQ_TRAP_EN
        bus.trap = $urandom_range(0, 99) < 10;
        bus.mret = $urandom_range(0, 99) < 10;
`endif
      end
    end
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
